// File: rtl/comparator_ncen_seq.sv
// Sequential winner-take-all comparator: streams NUM_CEN distances per frame, returns min and index.
// Optional runner-up outputs (out_min2/out_arg2) enabled by defining COMPARATOR_RUNNER_UP_EN.
module comparator_ncen_seq #(
    parameter int DATA_W  = 16,
    parameter int NUM_CEN = 8,
    parameter int IDX_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_min,
    output logic [IDX_W-1:0]  out_arg,
    output logic              out_valid,
`ifdef COMPARATOR_RUNNER_UP_EN
    output logic [DATA_W-1:0] out_min2,
    output logic [IDX_W-1:0]  out_arg2,
`endif
    input  logic              out_ready
);

    if (NUM_CEN < 2 || NUM_CEN > 256 || (1 << IDX_W) < NUM_CEN) begin : g_bad_params
        $error("comparator_ncen_seq: illegal NUM_CEN/IDX_W combination");
    end

    typedef enum logic {ACCUM, DONE} state_t;

    localparam logic [IDX_W:0] LAST = (IDX_W+1)'(NUM_CEN - 1);

    state_t            state;
    logic [IDX_W:0]    count;
    logic [DATA_W-1:0] run_min;
    logic [IDX_W-1:0]  run_arg;
    logic [DATA_W-1:0] nxt_min;
    logic [IDX_W-1:0]  nxt_arg;
    logic [IDX_W-1:0]  idx;
    logic              beat;
    logic              first;
    logic              less;

    assign in_ready = (state == ACCUM) && !rst;
    assign beat     = in_valid && in_ready;
    assign first    = (count == '0);
    assign idx      = count[IDX_W-1:0];
    assign less     = in_data < run_min;

    // Strict less-than keeps the lower index on ties.
    always_comb begin
        nxt_min = run_min;
        nxt_arg = run_arg;
        if (first) begin
            nxt_min = in_data;
            nxt_arg = '0;
        end else if (less) begin
            nxt_min = in_data;
            nxt_arg = idx;
        end
    end

`ifdef COMPARATOR_RUNNER_UP_EN
    logic [DATA_W-1:0] run_min2;
    logic [IDX_W-1:0]  run_arg2;
    logic [DATA_W-1:0] nxt_min2;
    logic [IDX_W-1:0]  nxt_arg2;

    always_comb begin
        nxt_min2 = run_min2;
        nxt_arg2 = run_arg2;
        if (first) begin
            nxt_min2 = '1;
            nxt_arg2 = '0;
        end else if (less) begin
            nxt_min2 = run_min;
            nxt_arg2 = run_arg;
        end else if (in_data < run_min2) begin
            nxt_min2 = in_data;
            nxt_arg2 = idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_min2 <= '0;
            run_arg2 <= '0;
            out_min2 <= '0;
            out_arg2 <= '0;
        end else if (!clear && state == ACCUM && beat) begin
            run_min2 <= nxt_min2;
            run_arg2 <= nxt_arg2;
            if (count == LAST) begin
                out_min2 <= nxt_min2;
                out_arg2 <= nxt_arg2;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            count     <= '0;
            run_min   <= '0;
            run_arg   <= '0;
            out_min   <= '0;
            out_arg   <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            state     <= ACCUM;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (beat) begin
                        run_min <= nxt_min;
                        run_arg <= nxt_arg;
                        if (count == LAST) begin
                            count     <= '0;
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_min   <= nxt_min;
                            out_arg   <= nxt_arg;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_ncen_seq.sv
// Directed bench for comparator_ncen_seq (NUM_CEN=8, DATA_W=16, IDX_W=3).
module tb_comparator_ncen_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_min;
    logic [2:0]  out_arg;
    logic        out_valid;
    logic        out_ready;
`ifdef COMPARATOR_RUNNER_UP_EN
    logic [15:0] out_min2;
    logic [2:0]  out_arg2;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    comparator_ncen_seq #(.DATA_W(16), .NUM_CEN(8), .IDX_W(3)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_min(out_min), .out_arg(out_arg), .out_valid(out_valid),
`ifdef COMPARATOR_RUNNER_UP_EN
        .out_min2(out_min2), .out_arg2(out_arg2),
`endif
        .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [15:0] d);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic frame(input logic [15:0] f [8]);
        for (int i = 0; i < 8; i++) beat(f[i]);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [15:0] f1 [8] = '{40, 12, 33, 12, 90, 7, 7, 100};
    logic [15:0] f3 [8] = '{9, 8, 7, 6, 5, 4, 3, 2};
    logic [15:0] f4 [8] = '{5, 1, 9, 9, 9, 9, 9, 9};
    logic [15:0] f5 [8] = '{6, 5, 4, 3, 2, 1, 0, 8};
    logic [15:0] f6 [8] = '{3, 2, 4, 4, 4, 4, 4, 4};
    logic [15:0] f7 [8] = '{50, 20, 30, 10, 60, 70, 80, 90};

    initial begin
        rst = 1'b1; clear = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_min", out_min, 0);
        chk("rst_out_arg", out_arg, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1 chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Frame 1: back-to-back, tie on 7 resolves to index 5
        for (int i = 0; i < 7; i++) beat(f1[i]);
        chk("f1_not_early", out_valid, 0);
        beat(f1[7]);
        chk("f1_valid", out_valid, 1);
        chk("f1_min", out_min, 7);
        chk("f1_arg", out_arg, 5);
        chk("f1_in_ready_done", in_ready, 0);
        handshake();
        chk("f1_valid_drop", out_valid, 0);
        chk("f1_in_ready_back", in_ready, 1);
        chk("f1_min_retained", out_min, 7);

        // Frame 2: all 0xFFFF, consumer stalls 5 cycles
        for (int i = 0; i < 8; i++) beat(16'hFFFF);
        for (int i = 0; i < 5; i++) begin
            chk("f2_hold_valid", out_valid, 1);
            chk("f2_hold_in_ready", in_ready, 0);
            idle(1);
        end
        chk("f2_min", out_min, 16'hFFFF);
        chk("f2_arg", out_arg, 0);
        handshake();
        chk("f2_valid_drop", out_valid, 0);

        // Frame 3: bubbles between beats
        for (int i = 0; i < 8; i++) begin
            idle($urandom_range(0, 3));
            chk("f3_no_early", out_valid, 0);
            beat(f3[i]);
        end
        chk("f3_valid", out_valid, 1);
        chk("f3_min", out_min, 2);
        chk("f3_arg", out_arg, 7);
        handshake();

        // Partial frame aborted by clear, beat in clear cycle is dropped
        beat(0); beat(0); beat(0);
        clear = 1'b1; in_valid = 1'b1; in_data = 0;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_no_result", out_valid, 0);
        for (int i = 0; i < 7; i++) beat(f4[i]);
        chk("f4_not_early", out_valid, 0);
        beat(f4[7]);
        chk("f4_valid", out_valid, 1);
        chk("f4_min", out_min, 1);
        chk("f4_arg", out_arg, 1);
        // clear in DONE wins over handshake
        clear = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; out_ready = 1'b0;
        chk("clr_done_valid", out_valid, 0);
        chk("clr_done_in_ready", in_ready, 1);

        // Async reset while result held
        frame(f5);
        chk("f5_valid", out_valid, 1);
        chk("f5_arg", out_arg, 6);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_min", out_min, 0);
        chk("arst_arg", out_arg, 0);
        chk("arst_in_ready", in_ready, 0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        frame(f6);
        chk("f6_valid", out_valid, 1);
        chk("f6_min", out_min, 2);
        chk("f6_arg", out_arg, 1);
        handshake();

        frame(f7);
        chk("f7_min", out_min, 10);
        chk("f7_arg", out_arg, 3);
`ifdef COMPARATOR_RUNNER_UP_EN
        chk("f7_min2", out_min2, 20);
        chk("f7_arg2", out_arg2, 1);
`endif
        handshake();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/comparator_ncen_seq.md
Name: comparator_ncen_seq

Overview:
Sequential winner-take-all comparator: accepts a stream of NUM_CEN unsigned centroid distances per frame, one per accepted beat. It returns the minimum distance and its centroid index. It is the parametrised successor to the fixed 4-centroid combinational tree, and sits between the distance-calculation stage and belief/centroid update in a DeSTIN node. It uses one comparator regardless of centroid count and adds valid/ready handshakes on both sides.

Parameters:
DATA_W, 16, width of each distance word (unsigned)
NUM_CEN, 8, centroids per frame; legal range 2..256
IDX_W, 3, index width; must satisfy 2**IDX_W >= NUM_CEN (elaboration error otherwise)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
clear  input  1  synchronous frame abort; discards partial frame and any pending result
in_data  input  DATA_W  distance for centroid in_idx order (arrival order = centroid index)
in_valid  input  1  in_data valid
in_ready  output  1  block accepts in_data this cycle
out_min  output  DATA_W  minimum distance of completed frame
out_arg  output  IDX_W  index of minimum
out_valid  output  1  result valid; held until out_ready
out_ready  input  1  consumer accepts result

Behaviour:
- Reset (async, rst=1): state=ACCUM, count=0, out_valid=0, out_min=0, out_arg=0, in_ready=0 while rst asserted, 1 in first cycle after release.
- States: ACCUM (collecting), DONE (result held).
- ACCUM: in_ready=1; beat accepted when in_valid&in_ready.
  - count==0 accepted: run_min<=in_data, run_arg<=0.
  - count>0 accepted: if in_data < run_min (strict unsigned), run_min<=in_data, run_arg<=count; else hold.
  - Ties: earlier (lower) index wins; matches the 2-centroid comparator's index=0 on equality.
  - count increments per accepted beat; when beat with count==NUM_CEN-1 accepted: count<=0, state<=DONE, out_valid<=1 next cycle, out_min/out_arg loaded with final comparison (including that last beat).
- DONE: in_ready=0; out_min/out_arg/out_valid stable. On out_valid&out_ready: out_valid<=0, state<=ACCUM.
- Latency: result visible 1 cycle after last accepted beat. Throughput: NUM_CEN+1 cycles per frame minimum (no accept during the handshake cycle).
- in_valid low mid-frame: stall, running state held indefinitely.
- clear (sync, any state): count<=0, out_valid<=0, state<=ACCUM; clear has priority over a simultaneous input beat and over a simultaneous output handshake (beat is dropped).
- rst mid-frame or in DONE: all state to reset values immediately; partial frame lost.
- count width: IDX_W+1 bits internally to avoid wrap at NUM_CEN=2**IDX_W.
- out_min/out_arg between frames retain last result (only out_valid qualifies them).

Optional Feature:
COMPARATOR_RUNNER_UP_EN
- Defined: adds outputs out_min2 (DATA_W) and out_arg2 (IDX_W), the second-smallest distance and its index, valid with out_valid. Update rule per beat: if in_data < run_min, runner-up<=old min/arg and min<=new; else if in_data < run_min2, runner-up<=new; ties keep earlier. At count==0, run_min2 initialised to all-ones, run_arg2 to 0. Reset value 0 for both outputs.
- Not defined: ports absent; no runner-up registers.

Test Plan:
- Reset then NUM_CEN=8 frame {40,12,33,12,90,7,7,100} back-to-back -> out_valid 1 cycle after 8th beat, out_min=7, out_arg=5 (tie to lower index).
- All-equal frame {0xFFFF x8} with out_ready held low 5 cycles -> out_min=0xFFFF, out_arg=0, out_valid held and in_ready=0 throughout; drops the cycle after out_ready=1.
- Frame with in_valid gapped (random bubbles) {9,8,7,6,5,4,3,2} -> out_arg=7, out_min=2; no beat lost or duplicated.
- Assert clear after 3 beats, then full frame {5,1,9,9,9,9,9,9} -> out_min=1, out_arg=1; no result from aborted partial frame.
- Async rst pulse (mid-cycle) while out_valid=1 -> out_valid=0, out_min=0, out_arg=0 immediately; next frame {3,2,...} processed from index 0.
- With COMPARATOR_RUNNER_UP_EN, frame {50,20,30,10,60,70,80,90} -> out_min=10/out_arg=3, out_min2=20/out_arg2=1.
